// File: rtl/uart_debug_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_debug_ctrl_pkg                                          |
// | Description : Command codes, reply codes, FSM state encoding and command   |
// |               decoder shared by the UART debug controller.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_debug_ctrl_pkg;

    // Host command bytes
    localparam logic [7:0] c_CMD_LOAD = 8'h4C;  // 'L' load instruction memory
    localparam logic [7:0] c_CMD_CONT = 8'h43;  // 'C' run until halt
    localparam logic [7:0] c_CMD_STEP = 8'h53;  // 'S' single step
    localparam logic [7:0] c_CMD_DUMP = 8'h44;  // 'D' dump register file

    // Reply bytes
    localparam logic [7:0] c_BYTE_ACK = 8'h06;
    localparam logic [7:0] c_BYTE_NAK = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LD_CNT   = 4'd1,
        ST_LD_BYTE  = 4'd2,
        ST_LD_WR    = 4'd3,
        ST_ACK      = 4'd4,
        ST_RUN      = 4'd5,
        ST_STEP     = 4'd6,
        ST_DUMP_CAP = 4'd7,
        ST_DUMP_TX  = 4'd8
    } dbg_state_t;

    // Maps a command byte to the state that serves it; ST_IDLE marks an unknown byte.
    function automatic dbg_state_t decode_cmd(input logic [7:0] b);
        dbg_state_t s;
        case (b)
            c_CMD_LOAD: s = ST_LD_CNT;
            c_CMD_CONT: s = ST_RUN;
            c_CMD_STEP: s = ST_STEP;
            c_CMD_DUMP: s = ST_DUMP_CAP;
            default:    s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_debug_ctrl_word_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dbg_word_tx                                                  |
// | Description : Serialises a word into UART bytes, LSB first, honouring TX   |
// |               FIFO backpressure. Length is given per load (1 for replies). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dbg_word_tx #(
    parameter int NB_WORD = 32,
    parameter int NB_BYTE = 8,
    parameter int NB_LEN  = 3
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [NB_WORD-1:0] i_word,
    input  logic [NB_LEN-1:0]  i_len,
    input  logic               i_tx_full,
    output logic               o_busy,
    output logic               o_wr,
    output logic [NB_BYTE-1:0] o_wdata
);

    logic [NB_WORD-1:0] shift_q;
    logic [NB_LEN-1:0]  left_q;
    logic               wr_q;
    logic [NB_BYTE-1:0] wdata_q;

    // Push one byte per decision; the gap after each push lets tx_full catch up
    // with the byte just written before the next one is considered.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            shift_q <= '0;
            left_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            wr_q <= 1'b0;
            if (i_load) begin
                shift_q <= i_word;
                left_q  <= i_len;
            end else if ((left_q != '0) && !i_tx_full && !wr_q) begin
                wr_q    <= 1'b1;
                wdata_q <= shift_q[NB_BYTE-1:0];
                shift_q <= shift_q >> NB_BYTE;
                left_q  <= left_q - NB_LEN'(1);
            end
        end
    end

    assign o_busy  = (left_q != '0) || wr_q;
    assign o_wr    = wr_q;
    assign o_wdata = wdata_q;

endmodule
`default_nettype wire

// File: rtl/uart_debug_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_debug_ctrl                                              |
// | Description : UART command sequencer: loads instruction memory, runs or    |
// |               single-steps the CPU and dumps the register file over TX.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_debug_ctrl
    import uart_debug_ctrl_pkg::*;
#(
    parameter int NB_INSTRUCTION  = 32,
    parameter int NB_DATA         = 32,
    parameter int IMEM_ADDR_WIDTH = 7,
    parameter int NB_UART_DATA    = 8,
    parameter int NB_REG_ADDR     = 5
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic [NB_UART_DATA-1:0]    i_uart_rx_data,
    input  logic                       i_uart_rx_empty,
    output logic                       o_uart_rd,
    input  logic                       i_uart_tx_full,
    output logic                       o_uart_wr,
    output logic [NB_UART_DATA-1:0]    o_uart_wdata,
    output logic                       o_uart_tx_start,
    output logic                       o_imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [NB_INSTRUCTION-1:0]  o_imem_wdata,
    output logic                       o_cpu_en,
    output logic                       o_cpu_rst,
    input  logic                       i_cpu_halt,
    output logic [NB_REG_ADDR-1:0]     o_dump_addr,
    input  logic [NB_DATA-1:0]         i_dump_data
);

    localparam int INSTR_BYTES = NB_INSTRUCTION / NB_UART_DATA;
    localparam int DATA_BYTES  = NB_DATA / NB_UART_DATA;
    localparam int NB_BIDX     = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
    localparam int NB_TXLEN    = $clog2(DATA_BYTES + 1);

    localparam logic [NB_BIDX-1:0]     c_LAST_BYTE = NB_BIDX'(INSTR_BYTES - 1);
    localparam logic [NB_REG_ADDR-1:0] c_LAST_REG  = '1;

    dbg_state_t                 state_q;
    logic                       rd_q;
    logic                       tx_start_q;
    logic                       imem_we_q;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr_q;
    logic [NB_INSTRUCTION-1:0]  imem_wdata_q;
    logic [IMEM_ADDR_WIDTH-1:0] ptr_q;
    logic [NB_UART_DATA-1:0]    cnt_q;
    logic [NB_BIDX-1:0]         bidx_q;
    logic                       cpu_en_q;
    logic                       cpu_rst_q;
    logic [NB_REG_ADDR-1:0]     dump_addr_q;
    logic                       tx_load_q;
    logic [NB_DATA-1:0]         tx_word_q;
    logic [NB_TXLEN-1:0]        tx_len_q;

    logic                       w_tx_busy;
    logic                       w_rx_ok;
    logic                       w_tx_idle;
    dbg_state_t                 w_cmd_state;

    // The popped head stays visible for one cycle after a pop, so never pop back to back.
    assign w_rx_ok     = !i_uart_rx_empty && !rd_q;
    // A load issued last cycle has not reached the serializer yet.
    assign w_tx_idle   = !w_tx_busy && !tx_load_q;
    assign w_cmd_state = decode_cmd(8'(i_uart_rx_data));

    // Command sequencer: all control outputs are registered here.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            rd_q         <= 1'b0;
            tx_start_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            bidx_q       <= '0;
            cpu_en_q     <= 1'b0;
            cpu_rst_q    <= 1'b1;
            dump_addr_q  <= '0;
            tx_load_q    <= 1'b0;
            tx_word_q    <= '0;
            tx_len_q     <= '0;
        end else begin
            rd_q       <= 1'b0;
            imem_we_q  <= 1'b0;
            tx_load_q  <= 1'b0;
            tx_start_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    cpu_en_q  <= 1'b0;
                    cpu_rst_q <= 1'b0;
                    // Waiting for the reply serializer keeps RX pops and TX pushes apart.
                    if (w_rx_ok && w_tx_idle) begin
                        rd_q    <= 1'b1;
                        state_q <= w_cmd_state;
                        case (w_cmd_state)
                            ST_LD_CNT:   cpu_rst_q   <= 1'b1;
                            ST_DUMP_CAP: dump_addr_q <= '0;
                            ST_IDLE: begin
                                tx_load_q <= 1'b1;
                                tx_word_q <= NB_DATA'(c_BYTE_NAK);
                                tx_len_q  <= NB_TXLEN'(1);
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LD_CNT: begin
                    if (w_rx_ok) begin
                        rd_q    <= 1'b1;
                        cnt_q   <= i_uart_rx_data;
                        ptr_q   <= '0;
                        bidx_q  <= '0;
                        state_q <= (i_uart_rx_data == '0) ? ST_ACK : ST_LD_BYTE;
                    end
                end
                ST_LD_BYTE: begin
                    // Bytes arrive LSB first: shift in from the top.
                    if (w_rx_ok) begin
                        rd_q         <= 1'b1;
                        imem_wdata_q <= {i_uart_rx_data, imem_wdata_q[NB_INSTRUCTION-1:NB_UART_DATA]};
                        if (bidx_q == c_LAST_BYTE) begin
                            bidx_q  <= '0;
                            state_q <= ST_LD_WR;
                        end else begin
                            bidx_q <= bidx_q + NB_BIDX'(1);
                        end
                    end
                end
                ST_LD_WR: begin
                    imem_we_q   <= 1'b1;
                    imem_addr_q <= ptr_q;
                    ptr_q       <= ptr_q + IMEM_ADDR_WIDTH'(1);
                    cnt_q       <= cnt_q - NB_UART_DATA'(1);
                    state_q     <= (cnt_q == NB_UART_DATA'(1)) ? ST_ACK : ST_LD_BYTE;
                end
                ST_ACK: begin
                    tx_load_q <= 1'b1;
                    tx_word_q <= NB_DATA'(c_BYTE_ACK);
                    tx_len_q  <= NB_TXLEN'(1);
                    cpu_rst_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                ST_RUN: begin
                    if (i_cpu_halt) begin
                        cpu_en_q    <= 1'b0;
                        dump_addr_q <= '0;
                        state_q     <= ST_DUMP_CAP;
                    end else begin
                        cpu_en_q <= 1'b1;
                    end
                end
                ST_STEP: begin
                    cpu_en_q    <= !i_cpu_halt;
                    dump_addr_q <= '0;
                    state_q     <= ST_DUMP_CAP;
                end
                ST_DUMP_CAP: begin
                    // Register data is valid one cycle after the address was driven.
                    cpu_en_q  <= 1'b0;
                    tx_load_q <= 1'b1;
                    tx_word_q <= i_dump_data;
                    tx_len_q  <= NB_TXLEN'(DATA_BYTES);
                    state_q   <= ST_DUMP_TX;
                end
                ST_DUMP_TX: begin
                    if (w_tx_idle) begin
                        if (dump_addr_q == c_LAST_REG) begin
                            state_q <= ST_IDLE;
                        end else begin
                            dump_addr_q <= dump_addr_q + NB_REG_ADDR'(1);
                            state_q     <= ST_DUMP_CAP;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    dbg_word_tx #(
        .NB_WORD (NB_DATA),
        .NB_BYTE (NB_UART_DATA),
        .NB_LEN  (NB_TXLEN)
    ) u_word_tx (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_load    (tx_load_q),
        .i_word    (tx_word_q),
        .i_len     (tx_len_q),
        .i_tx_full (i_uart_tx_full),
        .o_busy    (w_tx_busy),
        .o_wr      (o_uart_wr),
        .o_wdata   (o_uart_wdata)
    );

    assign o_uart_rd       = rd_q;
    assign o_uart_tx_start = tx_start_q;
    assign o_imem_we       = imem_we_q;
    assign o_imem_addr     = imem_addr_q;
    assign o_imem_wdata    = imem_wdata_q;
    assign o_cpu_en        = cpu_en_q;
    assign o_cpu_rst       = cpu_rst_q;
    assign o_dump_addr     = dump_addr_q;

endmodule
`default_nettype wire
